// File: rtl/uc_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encodings,
// opcode patterns, ALU operation codes and small opcode-class helpers.
package uc_multiciclo_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    // Fully specified opcodes (low six bits of the instruction word)
    localparam logic [5:0] OPC_NOP  = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b010000;
    localparam logic [5:0] OPC_JZ   = 6'b010001;
    localparam logic [5:0] OPC_JNZ  = 6'b010010;
    localparam logic [5:0] OPC_HALT = 6'b010011;

    // Load-immediate class: 0001??
    localparam logic [3:0] OPC_LI_PREFIX = 4'b0001;

    // ALU operation driven whenever the ALU is not in use
    localparam logic [2:0] ALU_OP_NONE = 3'b000;

    // ALU class: top opcode bit set, operation in bits [4:2]
    function automatic logic is_alu(input logic [5:0] opc);
        return opc[5];
    endfunction

    function automatic logic is_li(input logic [5:0] opc);
        return (opc[5:2] == OPC_LI_PREFIX);
    endfunction

endpackage

// File: rtl/uc_multiciclo_decoder.sv
// Combinational instruction decoder: IR and zero flag -> datapath strobes,
// plus HALT and undefined-opcode indications. Requires OPW >= 6; the opcode
// classes live in the low six bits of the instruction register.
module uc_multiciclo_decoder
    import uc_multiciclo_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] ir_i,
    input  logic           z_i,
    output logic           s_inc_o,
    output logic           s_inm_o,
    output logic           we3_o,
    output logic           wez_o,
    output logic [2:0]     op_o,
    output logic           is_halt_o,
    output logic           is_illegal_o
);

    logic [5:0] opc;
    assign opc = ir_i[5:0];

    // Decode table; defaults describe a sequential, side-effect-free step
    always_comb begin
        s_inc_o      = 1'b1;
        s_inm_o      = 1'b0;
        we3_o        = 1'b0;
        wez_o        = 1'b0;
        op_o         = ALU_OP_NONE;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        if (is_alu(opc)) begin
            op_o  = opc[4:2];
            we3_o = 1'b1;
            wez_o = 1'b1;
        end else if (is_li(opc)) begin
            s_inm_o = 1'b1;
            we3_o   = 1'b1;
        end else begin
            case (opc)
                OPC_NOP:  s_inc_o      = 1'b1;
                OPC_J:    s_inc_o      = 1'b0;
                OPC_JZ:   s_inc_o      = ~z_i;
                OPC_JNZ:  s_inc_o      = z_i;
                OPC_HALT: is_halt_o    = 1'b1;
                default:  is_illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the microc datapath. Every instruction runs
// FETCH -> DECODE -> EXEC; FETCH stalls on imem_ready and faults after
// WAIT_MAX idle cycles. All outputs are registered, so they reflect the
// state being occupied. Datapath strobes are asserted only in EXEC.
// The zero flag is sampled at the DECODE->EXEC edge, i.e. after the previous
// instruction's flag write has landed.
// Optional feature: define UC_PERF_EN to count retired instructions on
// instr_count; otherwise instr_count is tied to zero (same port list).
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int OPW      = 6,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   Opcode,
    input  logic             z,
    input  logic             imem_ready,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int          WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_e            state_q;
    logic [OPW-1:0]    ir_q;
    logic [WAIT_W-1:0] wait_q;
    logic              illegal_q;
    logic              s_inc_q, s_inm_q, we3_q, wez_q, pc_en_q, halted_q;
    logic [2:0]        op_q;

    logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_halt, dec_illegal;
    logic [2:0] dec_op;

    uc_multiciclo_decoder #(.OPW(OPW)) u_dec (
        .ir_i         (ir_q),
        .z_i          (z),
        .s_inc_o      (dec_s_inc),
        .s_inm_o      (dec_s_inm),
        .we3_o        (dec_we3),
        .wez_o        (dec_wez),
        .op_o         (dec_op),
        .is_halt_o    (dec_halt),
        .is_illegal_o (dec_illegal)
    );

    // Instruction sequencer with registered outputs for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            s_inc_q   <= 1'b0;
            s_inm_q   <= 1'b0;
            we3_q     <= 1'b0;
            wez_q     <= 1'b0;
            op_q      <= '0;
            pc_en_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            s_inc_q  <= 1'b1;
            s_inm_q  <= 1'b0;
            we3_q    <= 1'b0;
            wez_q    <= 1'b0;
            op_q     <= ALU_OP_NONE;
            pc_en_q  <= 1'b0;
            halted_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q    <= Opcode;
                        wait_q  <= '0;
                        state_q <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q    <= '0;
                        state_q   <= S_HALTED;
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        s_inc_q   <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        state_q   <= S_HALTED;
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        s_inc_q   <= 1'b0;
                    end else begin
                        state_q <= S_EXEC;
                        s_inc_q <= dec_s_inc;
                        s_inm_q <= dec_s_inm;
                        we3_q   <= dec_we3;
                        wez_q   <= dec_wez;
                        op_q    <= dec_op;
                        pc_en_q <= ~dec_halt;
                    end
                end
                S_EXEC: begin
                    if (dec_halt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                        s_inc_q  <= 1'b0;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    halted_q <= 1'b1;
                    s_inc_q  <= 1'b0;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign s_inc   = s_inc_q;
    assign s_inm   = s_inm_q;
    assign we3     = we3_q;
    assign wez     = wez_q;
    assign Op      = op_q;
    assign pc_en   = pc_en_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

`ifdef UC_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    // Retired-instruction counter: one count per EXEC cycle, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_EXEC) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo (default build or with UC_PERF_EN).
module tb_uc_multiciclo;

    localparam int OPW      = 6;
    localparam int CNT_W    = 16;
    localparam int WAIT_MAX = 15;
`ifdef UC_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [OPW-1:0]   Opcode;
    logic             z;
    logic             imem_ready;
    logic             s_inc, s_inm, we3, wez, pc_en, halted, illegal;
    logic [2:0]       Op;
    logic [CNT_W-1:0] instr_count;

    uc_multiciclo #(.OPW(OPW), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .z           (z),
        .imem_ready  (imem_ready),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .we3         (we3),
        .wez         (wez),
        .Op          (Op),
        .pc_en       (pc_en),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       pc_en;
        logic       halted;
        logic       illegal;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic obs_t mk(input logic si, input logic sm, input logic w3, input logic wz,
                                input logic [2:0] o, input logic pe, input logic h, input logic il);
        return {si, sm, w3, wz, o, pe, h, il};
    endfunction

    function automatic obs_t sample();
        return {s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal};
    endfunction

    // Drive one instruction fetch (after 'waits' not-ready cycles) and capture
    // the outputs in the third cycle after the fetch is accepted (EXEC slot).
    task automatic exec_instr(input logic [5:0] opc, input logic zv, input int waits, output obs_t obs);
        Opcode     = opc;
        z          = zv;
        imem_ready = 1'b0;
        repeat (waits) @(posedge clk);
        #1 imem_ready = 1'b1;
        @(posedge clk);
        #1 imem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obs = sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b1; imem_ready = 1'b1; Opcode = 6'b000000; z = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sample() !== obs_t'(0) || instr_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b cnt=%0d, want all zero", sample(), instr_count);
        end
        reset = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 3'b000, 1, 0, 0));
        exec_instr(6'b000000, 1'b0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_first_nop: got %b, want %b", o, e);
        end
    endtask

    task automatic test_alu();
        obs_t o, e;
        exp_q.push_back(mk(1, 0, 1, 1, 3'b001, 1, 0, 0));
        exec_instr(6'b100100, 1'b0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL alu_100100: got %b, want %b", o, e); end
        exp_q.push_back(mk(1, 0, 1, 1, 3'b111, 1, 0, 0));
        exec_instr(6'b111100, 1'b1, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL alu_111100: got %b, want %b", o, e); end
    endtask

    task automatic test_jumps();
        logic [5:0] opcs [5] = '{6'b010000, 6'b010001, 6'b010001, 6'b010010, 6'b010010};
        logic       zs   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       sinc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        obs_t o, e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(sinc[i], 0, 0, 0, 3'b000, 1, 0, 0));
            exec_instr(opcs[i], zs[i], 0, o);
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL jump_%b_z%0d: got %b, want %b", opcs[i], zs[i], o, e);
            end
        end
    endtask

    task automatic test_wait_li();
        obs_t o, e;
        exp_q.push_back(mk(1, 1, 1, 0, 3'b000, 1, 0, 0));
        exec_instr(6'b000110, 1'b0, 3, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL li_after_wait3: got %b, want %b", o, e); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        do_reset();
        exp_q.push_back(mk(1, 0, 1, 1, 3'b010, 1, 0, 0));
        exp_q.push_back(mk(1, 1, 1, 0, 3'b000, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 3'b000, 1, 0, 0));
        exec_instr(6'b101000, 1'b0, 10, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_alu_wait10: got %b, want %b", o, e); end
        exec_instr(6'b000101, 1'b0, 10, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_li_wait10: got %b, want %b", o, e); end
        exec_instr(6'b000000, 1'b0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_nop: got %b, want %b", o, e); end
        n_tests++;
        if (instr_count !== CNT_W'(PERF * 3)) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, want %0d", instr_count, PERF * 3);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] bad [3] = '{6'b001000, 6'b010100, 6'b011111};
        obs_t o, e;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            exp_q.push_back(mk(0, 0, 0, 0, 3'b000, 0, 1, 1));
            exec_instr(bad[i], 1'b0, 0, o);
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL illegal_%b: got %b, want %b", bad[i], o, e); end
        end
        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (pc_en !== 1'b0 || halted !== 1'b1 || illegal !== 1'b1 || instr_count !== '0) begin
            n_fail++;
            $display("FAIL illegal_stays_halted: pc_en=%b halted=%b illegal=%b cnt=%0d, want 0 1 1 0",
                     pc_en, halted, illegal, instr_count);
        end
        do_reset();
        @(negedge clk);
        n_tests++;
        if (illegal !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_cleared_by_reset: illegal=%b halted=%b, want 0 0", illegal, halted);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        imem_ready = 1'b0;
        repeat (WAIT_MAX - 1) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (halted !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: halted=%b illegal=%b, want 0 0", halted, illegal);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (halted !== 1'b1 || illegal !== 1'b1 || pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: halted=%b illegal=%b pc_en=%b, want 1 1 0", halted, illegal, pc_en);
        end
    endtask

    task automatic test_halt_and_mid_reset();
        obs_t o, e;
        do_reset();
        exp_q.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 0));
        exec_instr(6'b010011, 1'b0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL halt_exec: got %b, want %b", o, e); end
        imem_ready = 1'b1;
        Opcode     = 6'b000000;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (halted !== 1'b1 || pc_en !== 1'b0 || illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_holds: halted=%b pc_en=%b illegal=%b, want 1 0 0", halted, pc_en, illegal);
            end
        end
        do_reset();
        Opcode     = 6'b100100;
        imem_ready = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        imem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sample() !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_in_decode: got %b, want all zero", sample());
        end
        reset = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 3'b000, 1, 0, 0));
        exec_instr(6'b000000, 1'b0, 0, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL after_mid_reset_nop: got %b, want %b", o, e); end
    endtask

    task automatic test_perf();
        obs_t o;
        do_reset();
        for (int i = 0; i < 5; i++) exec_instr(6'b000000, 1'b0, 0, o);
        n_tests++;
        if (instr_count !== CNT_W'(PERF * 5)) begin
            n_fail++;
            $display("FAIL perf_5_nops: got %0d, want %0d", instr_count, PERF * 5);
        end
        exec_instr(6'b010011, 1'b0, 0, o);
        n_tests++;
        if (instr_count !== CNT_W'(PERF * 6) || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL perf_halt_counts: cnt=%0d halted=%b, want %0d 1", instr_count, halted, PERF * 6);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_jumps();
        test_wait_li();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_halt_and_mid_reset();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
